// File: rtl/gf2mz_packer.sv
// -----------------------------------------------------------------------------
// gf2mz_packer
// Loads one operand polynomial of the GF(2^m)[z] multiplier into its
// single-port operand memory. Coefficients arrive one per transfer in index
// order. They are packed d per word, lane 0 in the MSB slice, and the
// ceil(n/d) words are written to ascending addresses starting at 0.
//
// Ports
//   clk       : single clock, rising edge
//   rst_b     : synchronous reset, active HIGH despite the name
//   start     : begin a load (sampled only while idle)
//   in_valid  : in_data carries a coefficient
//   in_data   : m-bit coefficient
//   in_ready  : block accepts in_data this cycle (registered)
//   mem_we    : one-cycle write strobe to the operand memory
//   mem_addr  : word address, held between writes
//   mem_do    : packed word, held between writes
//   busy      : load in progress (LOAD, FLUSH, DONE)
//   done      : one-cycle pulse after the last word has been written
// -----------------------------------------------------------------------------
module gf2mz_packer #(
   parameter int n     = 83,
   parameter int m     = 67,
   parameter int d     = 5,
   parameter int WIDTH = m * d,
   parameter int DEPTH = (n / d) + (((n % d) != 0) ? 1 : 0),
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             start,
   input  logic             in_valid,
   input  logic [m-1:0]     in_data,
   output logic             in_ready,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [WIDTH-1:0] mem_do,
   output logic             busy,
   output logic             done
);

   localparam int IW = (n > 1) ? $clog2(n) : 1;
   localparam int JW = (d > 1) ? $clog2(d) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   logic [IW-1:0]    r_i;      // index of the next coefficient
   logic [JW-1:0]    r_j;      // next lane within the current word
   logic [AW-1:0]    r_w;      // address of the word being assembled
   logic [WIDTH-1:0] r_acc;    // partially filled word
   logic             r_ready;
   logic             r_we;
   logic [AW-1:0]    r_addr;
   logic [WIDTH-1:0] r_do;
   logic             r_busy;
   logic             r_done;

   logic             w_xfer;
   logic             w_last;
   logic             w_full;
   logic             w_complete;
   logic [WIDTH-1:0] w_acc_new;

   // r_ready is high exactly while in LOAD, so it doubles as the state qualifier.
   assign w_xfer     = in_valid & r_ready;
   assign w_last     = (r_i == IW'(n - 1));
   assign w_full     = (r_j == JW'(d - 1));
   assign w_complete = w_xfer & (w_last | w_full);

   // Accumulator with the incoming coefficient merged into lane r_j. Lanes
   // beyond r_j are still zero, which gives the zero padding of a short
   // final word for free.
   for (genvar gi = 0; gi < d; gi++) begin : g_lane
      assign w_acc_new[WIDTH-1-gi*m -: m] =
         (r_j == JW'(gi)) ? in_data : r_acc[WIDTH-1-gi*m -: m];
   end

   always_ff @(posedge clk) begin
      if (rst_b) begin
         r_state <= S_IDLE;
         r_i     <= '0;
         r_j     <= '0;
         r_w     <= '0;
         r_acc   <= '0;
         r_ready <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_do    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_we   <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_i     <= '0;
                  r_j     <= '0;
                  r_w     <= '0;
                  r_acc   <= '0;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (w_xfer) begin
                  r_i <= r_i + 1'b1;
                  if (w_complete) begin
                     // The word goes to its own output register so the
                     // accumulator is free for the very next coefficient.
                     r_we   <= 1'b1;
                     r_addr <= r_w;
                     r_do   <= w_acc_new;
                     r_acc  <= '0;
                     r_j    <= '0;
                     r_w    <= r_w + 1'b1;
                  end else begin
                     r_acc <= w_acc_new;
                     r_j   <= r_j + 1'b1;
                  end
                  if (w_last) begin
                     r_ready <= 1'b0;
                     r_state <= S_FLUSH;
                  end
               end
            end
            S_FLUSH: begin
               // The final write strobe is visible during this cycle.
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready = r_ready;
   assign mem_we   = r_we;
   assign mem_addr = r_addr;
   assign mem_do   = r_do;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule
